// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the register file: clears regs 1..NREGS-1 after reset, then arbitrates two writeback ports.
// Define REGFILE_WRCTRL_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module regfile_write_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              v0,
   output logic              rdy0,
   input  logic [ADDR_W-1:0] a0,
   input  logic [DATA_W-1:0] d0,
   input  logic              v1,
   output logic              rdy1,
   input  logic [ADDR_W-1:0] a1,
   input  logic [DATA_W-1:0] d1,
   output logic              wren,
   output logic [ADDR_W-1:0] wr,
   output logic [DATA_W-1:0] wd,
   output logic              init_done,
   output logic              dbg_state_o
);

   // Handshake: a write is transferred in any cycle where vN && rdyN; rdyN is
   // combinational from v0/v1/hold/state/pointer and never from aN/dN.
   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                wren_q, wren_d;
   logic [ADDR_W-1:0]   wr_q, wr_d;
   logic [DATA_W-1:0]   wd_q, wd_d;
   logic                init_done_q, init_done_d;
   logic                g0, g1;

`ifdef REGFILE_WRCTRL_RR_EN
   // Pointer names the port granted last; a tie goes to the other port.
   logic ptr_q, ptr_d;

   always_comb begin
      g0 = v0 && (!v1 || ptr_q);
      g1 = v1 && (!v0 || !ptr_q);
   end
`else
   always_comb begin
      g0 = v0;
      g1 = v1 && !v0;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_INIT;
         cnt_q       <= ADDR_W'(1);
         wren_q      <= 1'b0;
         wr_q        <= '0;
         wd_q        <= '0;
         init_done_q <= 1'b0;
`ifdef REGFILE_WRCTRL_RR_EN
         ptr_q       <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wren_q      <= wren_d;
         wr_q        <= wr_d;
         wd_q        <= wd_d;
         init_done_q <= init_done_d;
`ifdef REGFILE_WRCTRL_RR_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wren_d      = 1'b0;
      wr_d        = wr_q;
      wd_d        = wd_q;
      init_done_d = init_done_q;
      rdy0        = 1'b0;
      rdy1        = 1'b0;
`ifdef REGFILE_WRCTRL_RR_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         S_INIT: begin
            if (!hold) begin
               wren_d = 1'b1;
               wr_d   = cnt_q;
               wd_d   = '0;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  init_done_d = 1'b1;
                  state_d     = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (!hold) begin
               rdy0 = g0;
               rdy1 = g1;
               // Register 0 completes the handshake but never reaches the file.
               if (g0) begin
                  wr_d   = a0;
                  wd_d   = d0;
                  wren_d = (a0 != '0);
`ifdef REGFILE_WRCTRL_RR_EN
                  ptr_d  = 1'b0;
`endif
               end else if (g1) begin
                  wr_d   = a1;
                  wd_d   = d1;
                  wren_d = (a1 != '0);
`ifdef REGFILE_WRCTRL_RR_EN
                  ptr_d  = 1'b1;
`endif
               end
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   assign wren        = wren_q;
   assign wr          = wr_q;
   assign wd          = wd_q;
   assign init_done   = init_done_q;
   assign dbg_state_o = (state_q == S_RUN);

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: clear sequence, table-driven arbitration vectors, hold and mid-INIT reset.
module tb_regfile_write_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hold = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [4:0]  a0 = '0, a1 = '0;
   logic [31:0] d0 = '0, d1 = '0;
   logic        rdy0, rdy1, wren, init_done, dbg_state;
   logic [4:0]  wr;
   logic [31:0] wd;

   int n_cmp = 0;
   int n_err = 0;

`ifdef REGFILE_WRCTRL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   regfile_write_ctrl #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .v0(v0), .rdy0(rdy0), .a0(a0), .d0(d0),
      .v1(v1), .rdy1(rdy1), .a1(a1), .d1(d1),
      .wren(wren), .wr(wr), .wd(wd), .init_done(init_done),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hold, v0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        e_rdy0, e_rdy1, e_wren;
      logic [4:0]  e_wr;
      logic [31:0] e_wd;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic h, input logic iv0, input logic [4:0] ia0,
                               input logic [31:0] id0, input logic iv1, input logic [4:0] ia1,
                               input logic [31:0] id1, input logic r0, input logic r1,
                               input logic we, input logic [4:0] ewr, input logic [31:0] ewd);
      vec_t v;
      v.hold = h; v.v0 = iv0; v.a0 = ia0; v.d0 = id0;
      v.v1 = iv1; v.a1 = ia1; v.d1 = id1;
      v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_wren = we; v.e_wr = ewr; v.e_wd = ewd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      // Arbitration vectors, applied from RUN with wr=0, wd=1234, pointer=1.
      tbl[0]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 32'h1234);
      tbl[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  1, 0, 1, 5, 32'hDEADBEEF);
      tbl[2]  = mk(0, 0, 0, 32'h0,        1, 9, 32'h99, 0, 1, 1, 9, 32'h99);
      tbl[3]  = mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11);
      tbl[4]  = mk(0, 1, 1, 32'h11, 1, 2, 32'h22, !RR, RR, 1, RR ? 5'd2 : 5'd1, RR ? 32'h22 : 32'h11);
      tbl[5]  = mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11);
      tbl[6]  = mk(0, 1, 1, 32'h11, 1, 2, 32'h22, !RR, RR, 1, RR ? 5'd2 : 5'd1, RR ? 32'h22 : 32'h11);
      for (int i = 7; i <= 9; i++)
         tbl[i] = mk(1, 1, 3, 32'h33, 0, 0, 32'h0, 0, 0, 0, RR ? 5'd2 : 5'd1, RR ? 32'h22 : 32'h11);
      tbl[10] = mk(0, 1, 3, 32'h33, 0, 0, 32'h0,  1, 0, 1, 3, 32'h33);
      tbl[11] = mk(0, 1, 4, 32'h44, 1, 6, 32'h66, !RR, RR, 1, RR ? 5'd6 : 5'd4, RR ? 32'h66 : 32'h44);
      tbl[12] = mk(0, 1, 0, 32'h55, 0, 0, 32'h0,  1, 0, 0, 0, 32'h55);
      tbl[13] = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 32'h55);
      tbl[14] = mk(0, 1, 8, 32'hA0, 1, 8, 32'hB0, !RR, RR, 1, 8, RR ? 32'hB0 : 32'hA0);
      tbl[15] = mk(0, 1, 8, 32'hA0, 1, 8, 32'hB0, 1, 0, 1, 8, 32'hA0);

      // Reset state, with port 1 requesting register 0 throughout INIT.
      v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
      repeat (2) @(negedge clk);
      chk("rst_wren", wren, 0);
      chk("rst_wr", wr, 0);
      chk("rst_wd", wd, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_rdy1", rdy1, 0);
      rst = 1'b0;
      #1 chk("init_rdy1_pre", rdy1, 0);

      for (int i = 1; i <= 31; i++) begin
         @(posedge clk); #1;
         chk($sformatf("init_wren_%0d", i), wren, 1);
         chk($sformatf("init_wr_%0d", i), wr, i);
         chk($sformatf("init_wd_%0d", i), wd, 0);
         chk($sformatf("init_done_%0d", i), init_done, (i == 31));
         chk($sformatf("init_rdy0_%0d", i), rdy0, 0);
         chk($sformatf("init_rdy1_%0d", i), rdy1, (i == 31));
      end
      // Register-0 write from port 1 handshakes but must not enable the file.
      @(posedge clk); #1;
      chk("r0_wren", wren, 0);
      chk("r0_wr", wr, 0);
      chk("r0_wd", wd, 32'h1234);
      chk("run_state", dbg_state, 1);
      @(negedge clk);
      v1 = 1'b0;

      for (int i = 0; i < 16; i++) begin
         hold = tbl[i].hold;
         v0 = tbl[i].v0; a0 = tbl[i].a0; d0 = tbl[i].d0;
         v1 = tbl[i].v1; a1 = tbl[i].a1; d1 = tbl[i].d1;
         #1;
         chk($sformatf("vec%0d_rdy0", i), rdy0, tbl[i].e_rdy0);
         chk($sformatf("vec%0d_rdy1", i), rdy1, tbl[i].e_rdy1);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_wren", i), wren, tbl[i].e_wren);
         chk($sformatf("vec%0d_wr", i), wr, tbl[i].e_wr);
         chk($sformatf("vec%0d_wd", i), wd, tbl[i].e_wd);
         chk($sformatf("vec%0d_init_done", i), init_done, 1);
         @(negedge clk);
      end

      // Restart INIT, then reset asynchronously while wr=12.
      hold = 1'b0; v0 = 1'b0; v1 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         chk($sformatf("pre_wr_%0d", i), wr, i);
      end
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_wren", wren, 0);
      chk("mid_rst_wr", wr, 0);
      chk("mid_rst_wd", wd, 0);
      chk("mid_rst_init_done", init_done, 0);
      chk("mid_rst_state", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         if (i == 6) begin
            // Two held edges during INIT: no write and the counter must not advance.
            hold = 1'b1;
            repeat (2) begin
               @(posedge clk); #1;
               chk("hold_init_wren", wren, 0);
               chk("hold_init_wr", wr, 5);
               chk("hold_init_done", init_done, 0);
            end
            @(negedge clk);
            hold = 1'b0;
         end
         @(posedge clk); #1;
         chk($sformatf("re_wren_%0d", i), wren, 1);
         chk($sformatf("re_wr_%0d", i), wr, i);
         chk($sformatf("re_done_%0d", i), init_done, (i == 31));
      end
      @(posedge clk); #1;
      chk("re_idle_wren", wren, 0);
      chk("re_state", dbg_state, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 32×32 register file. It owns the file's single write port: after reset it clears registers 1..31, then arbitrates between two writeback requesters over valid/ready. Requester 0 is the ALU writeback and requester 1 is the load/mul-div writeback. Grants are registered onto the file's wren/wr/wd, and writes to register 0 are discarded.

## Interface
Parameters:
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width
- NREGS, 32, register count; init clears 1..NREGS-1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  freezes the write port (pipeline stall)
- v0  in  1  requester 0 write valid
- rdy0  out  1  requester 0 accepted; combinational
- a0  in  ADDR_W  requester 0 destination register
- d0  in  DATA_W  requester 0 write data
- v1, rdy1, a1, d1  same as port 0, for requester 1
- wren  out  1  register-file write enable; registered
- wr  out  ADDR_W  register-file write address; registered
- wd  out  DATA_W  register-file write data; registered
- init_done  out  1  high once the clear sequence has issued its last write

## Operation
- States: INIT and RUN. A 5-bit counter cnt drives INIT.
- Reset values: state=INIT, cnt=1, wren=0, wr=0, wd=0, init_done=0, rr pointer=1 (port 0 wins the first tie).
- INIT, hold=0, at each posedge: wren<=1, wr<=cnt, wd<=0, cnt<=cnt+1.
  - On the edge that issues cnt==NREGS-1: init_done<=1 and state<=RUN.
- INIT, hold=1: wren<=0 and cnt holds.
- rdy0 and rdy1 are 0 throughout INIT.
- RUN, hold=1: rdy0=rdy1=0 and wren<=0.
- RUN, hold=0, grant selection (at most one grant per cycle):
  - only v0: rdy0=1
  - only v1: rdy1=1
  - both valid: grant the port that is not the rr pointer
- Transfer occurs when vN && rdyN. On the next posedge:
  - wr<=aN, wd<=dN
  - wren<=(aN!=0)
  - pointer<=N
- No transfer: wren<=0. wr and wd hold their last values.
- Requests for register 0 complete the handshake normally but never assert wren.
- The two ports may target the same address. Writes are serialised in grant order, so the later grant wins in the file.
- A requester must hold vN, aN and dN stable until rdyN. The controller does not check this.
- rst asserted at any time, including mid-INIT, immediately restores all reset values. After release, the clear sequence restarts from register 1.

## Timing
- Write latency is 1 cycle: a transfer in cycle t appears on wren/wr/wd during cycle t+1, and the file commits it at the end of t+1.
- rdyN depends combinationally on v0, v1, hold, state and pointer. It does not depend on aN or dN.
- INIT length without hold: NREGS-1 = 31 consecutive write cycles.
  - First posedge after rst release: wr=1.
  - 31st posedge: wr=31 and init_done=1.
  - rdy can assert in the cycle after that 31st edge.
- hold takes effect in the same cycle for rdy and on the next edge for wren.
- Sustained throughput is one write per cycle. Each port gets at least one grant in every two cycles while both are continuously valid (with round-robin compiled in).

## Configuration
- REGFILE_WRCTRL_RR_EN defined:
  - round-robin arbitration as described above
  - the pointer register exists and updates on each transfer
- Not defined:
  - fixed priority; port 0 always wins when both are valid
  - no pointer register
  - port 1 is granted only when v0=0
- INIT, hold, register-0 suppression and latency are identical in both builds.

## Test plan
- Reset release, hold=0, no requests -> wren=1 for 31 cycles with wr=1..31 and wd=0; init_done rises with wr=31; then wren=0.
- After init, v0=1, a0=5, d0=0xDEADBEEF for one cycle -> rdy0=1 that cycle; next cycle wren=1, wr=5, wd=0xDEADBEEF.
- Both ports valid for 4 cycles (a0=1, a1=2), RR build -> grant order 0,1,0,1 and wr sequence 1,2,1,2. Non-RR build -> four port-0 grants and rdy1=0 throughout.
- v1=1, a1=0, d1=0x1234 -> rdy1=1 and the handshake completes; wren stays 0 the next cycle.
- hold=1 for 3 cycles with v0 asserted -> rdy0=0 and wren=0 during the hold; v0 is granted in the first cycle after hold drops.
- rst pulsed while wr=12 during INIT -> outputs return to reset values immediately; after release the clear sequence restarts at wr=1 and takes a full 31 cycles.
